// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared state encoding, bus width defaults and result shaping
package neuron_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_X,
    RD_W,
    MAC,
    WR,
    DONE
  } state_t;

  // Arithmetic shift, clamp to the signed data_w range, then optional ReLU.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] acc,
    input int                 shift,
    input int                 data_w,
    input logic               relu
  );
    logic signed [63:0] t;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    t  = acc >>> shift;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (t > hi) begin
      t = hi;
    end else if (t < lo) begin
      t = lo;
    end
    if (relu && (t < 64'sd0)) begin
      t = 64'sd0;
    end
    return t;
  endfunction

endpackage

// File: rtl/neuron_layer_seq_mac_sat.sv
// rtl/neuron_layer_seq_mac_sat.sv - signed multiply, registered accumulate, saturating result
module neuron_mac_sat
  import neuron_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = 20,
  parameter int SHIFT  = 0,
  parameter int RELU   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] w_i,
  output logic [DATA_W-1:0] res_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;

  assign prod     = $signed(x_i) * $signed(w_i);
  assign prod_ext = ACC_W'(prod);

  // Clear wins over accumulate so a new neuron always starts from zero.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign res_o = DATA_W'(sat_shift(64'(acc_q), SHIFT, DATA_W, RELU != 0));

endmodule

// File: rtl/neuron_layer_seq.sv
// rtl/neuron_layer_seq.sv - fully-connected layer sequencer over a scratch memory
module neuron_layer_seq
  import neuron_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int N_IN     = 4,
  parameter int N_OUT    = 4,
  parameter int IN_BASE  = 0,
  parameter int W_BASE   = 16,
  parameter int OUT_BASE = 64,
  parameter int ACC_W    = 20,
  parameter int SHIFT    = 0,
  parameter int RELU     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              ack,
  output logic              busy,
  output logic              trig_r,
  output logic              trig_w,
  output logic [ADDR_W-1:0] abus_r,
  output logic [ADDR_W-1:0] abus_w,
  input  logic [DATA_W-1:0] dbus_r,
  output logic [DATA_W-1:0] dbus_w
);

  localparam int CNT_W = 5;
  localparam longint ACC_MAX  = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_NEED = longint'(N_IN) <<< (2 * DATA_W - 2);

  if (ACC_MAX < ACC_NEED) begin : g_acc_w_too_small
    $error("neuron_layer_seq: ACC_W too narrow for N_IN products");
  end

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    i_q, i_d;
  logic [CNT_W-1:0]    j_q, j_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic [DATA_W-1:0]   w_q, w_d;
  logic                acc_clr;
  logic                mac_en;
  logic [DATA_W-1:0]   res;

  neuron_mac_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT),
    .RELU   (RELU)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (acc_clr),
    .en_i  (mac_en),
    .x_i   (x_q),
    .w_i   (w_q),
    .res_o (res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      x_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      x_q     <= x_d;
      w_q     <= w_d;
    end
  end

  // Outputs decode from the registered state so a WR cycle holds its strobe for the full period.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    x_d     = x_q;
    w_d     = w_q;
    acc_clr = 1'b0;
    mac_en  = 1'b0;
    ack     = 1'b0;
    busy    = 1'b0;
    trig_r  = 1'b0;
    trig_w  = 1'b0;
    abus_r  = '0;
    abus_w  = '0;
    dbus_w  = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = RD_X;
          i_d     = '0;
          j_d     = '0;
          acc_clr = 1'b1;
        end
      end
      RD_X: begin
        busy    = 1'b1;
        trig_r  = 1'b1;
        abus_r  = ADDR_W'(IN_BASE + int'(i_q));
        x_d     = dbus_r;
        state_d = RD_W;
      end
      RD_W: begin
        busy    = 1'b1;
        trig_r  = 1'b1;
        abus_r  = ADDR_W'(W_BASE + int'(j_q) * N_IN + int'(i_q));
        w_d     = dbus_r;
        state_d = MAC;
      end
      MAC: begin
        busy   = 1'b1;
        mac_en = 1'b1;
        if (i_q == CNT_W'(N_IN - 1)) begin
          state_d = WR;
        end else begin
          i_d     = i_q + CNT_W'(1);
          state_d = RD_X;
        end
      end
      WR: begin
        busy    = 1'b1;
        trig_w  = 1'b1;
        abus_w  = ADDR_W'(OUT_BASE + int'(j_q));
        dbus_w  = res;
        i_d     = '0;
        acc_clr = 1'b1;
        if (j_q == CNT_W'(N_OUT - 1)) begin
          state_d = DONE;
        end else begin
          j_d     = j_q + CNT_W'(1);
          state_d = RD_X;
        end
      end
      DONE: begin
        busy    = 1'b1;
        ack     = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_neuron_layer_seq.sv
// tb/tb_neuron_layer_seq.sv - scoreboard bench for the layer sequencer (plain, ReLU and shifted instances)
module tb_neuron_layer_seq;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic [2:0] ack;
  logic [2:0] busy;
  logic [2:0] trig_r;
  logic [2:0] trig_w;
  logic [7:0] abus_r [3];
  logic [7:0] abus_w [3];
  logic [7:0] dbus_r [3];
  logic [7:0] dbus_w [3];

  logic [7:0]  mem [3][256];
  logic [15:0] sb  [3][$];
  int          ack_cnt [3];
  int          ack_cyc [$];
  int          cyc;
  int          checks;
  int          failures;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    neuron_layer_seq #(
      .SHIFT (g == 2 ? 4 : 0),
      .RELU  (g == 1 ? 1 : 0)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req[g]),
      .ack    (ack[g]),
      .busy   (busy[g]),
      .trig_r (trig_r[g]),
      .trig_w (trig_w[g]),
      .abus_r (abus_r[g]),
      .abus_w (abus_w[g]),
      .dbus_r (dbus_r[g]),
      .dbus_w (dbus_w[g])
    );

    initial begin
      forever begin
        @(negedge clk);
        if (trig_w[g]) mem[g][abus_w[g]] = dbus_w[g];
        dbus_r[g] = mem[g][abus_r[g]];
      end
    end

    initial begin
      logic [15:0] exp_wr;
      ack_cnt[g] = 0;
      forever begin
        @(negedge clk);
        if (ack[g]) begin
          ack_cnt[g]++;
          if (g == 0) ack_cyc.push_back(cyc);
        end
        if (trig_w[g]) begin
          if (sb[g].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write dut%0d actual=%0h required=none", g, {abus_w[g], dbus_w[g]});
          end else begin
            exp_wr = sb[g].pop_front();
            check($sformatf("write_dut%0d", g), {abus_w[g], dbus_w[g]}, exp_wr);
          end
        end
      end
    end
  end

  task automatic load_mem(input bit neg);
    for (int g = 0; g < 3; g++) begin
      for (int a = 0; a < 256; a++) mem[g][a] = 8'(a) ^ 8'h5A;
      for (int i = 0; i < 4; i++) begin
        mem[g][i]      = neg ? 8'h80 : 8'(i + 1);
        mem[g][16 + i] = neg ? 8'h7F : 8'h01;
        mem[g][20 + i] = 8'hFF;
        mem[g][24 + i] = 8'h7F;
        mem[g][28 + i] = 8'h00;
      end
    end
  endtask

  task automatic push_run(input int g, input logic [7:0] y0, input logic [7:0] y1,
                          input logic [7:0] y2, input logic [7:0] y3);
    sb[g].push_back({8'd64, y0});
    sb[g].push_back({8'd65, y1});
    sb[g].push_back({8'd66, y2});
    sb[g].push_back({8'd67, y3});
  endtask

  task automatic run_pulse(input logic [2:0] mask, input string tag);
    int t0;
    int lat;
    int busy_low;
    bit seen;
    @(posedge clk);
    #1 req = mask;
    t0 = cyc;
    @(posedge clk);
    #1 req = 3'b000;
    busy_low = 0;
    seen     = 1'b0;
    lat      = -1;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (ack[0]) begin
        seen = 1'b1;
        lat  = cyc - t0;
      end else if (!busy[0]) begin
        busy_low++;
      end
    end
    check({tag, "_ack_latency"}, lat, 53);
    check({tag, "_busy_low_cycles"}, busy_low, 0);
  endtask

  initial begin
    int base;
    int t0;
    int diffs;
    logic [7:0] img [256];
    checks   = 0;
    failures = 0;
    req      = 3'b000;
    rst      = 1'b1;
    load_mem(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {ack[0], busy[0], trig_r[0], trig_w[0], abus_r[0], abus_w[0], dbus_w[0]}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // basic data on all three instances
    push_run(0, 8'd10, 8'hF6, 8'd127, 8'd0);
    push_run(1, 8'd10, 8'd0,  8'd127, 8'd0);
    push_run(2, 8'd0,  8'hFF, 8'h4F,  8'd0);
    run_pulse(3'b111, "basic");
    repeat (3) @(negedge clk);
    check("ack_count_relu", ack_cnt[1], 1);
    check("ack_count_shift", ack_cnt[2], 1);
    for (int a = 0; a < 256; a++) img[a] = 8'(a) ^ 8'h5A;
    for (int i = 0; i < 4; i++) begin
      img[i]      = 8'(i + 1);
      img[16 + i] = 8'h01;
      img[20 + i] = 8'hFF;
      img[24 + i] = 8'h7F;
      img[28 + i] = 8'h00;
    end
    img[64] = 8'd10; img[65] = 8'd0; img[66] = 8'd127; img[67] = 8'd0;
    diffs = 0;
    for (int a = 0; a < 256; a++) if (mem[1][a] !== img[a]) diffs++;
    check("relu_mem_image_diffs", diffs, 0);

    // negative saturation
    load_mem(1'b1);
    push_run(0, 8'h80, 8'h7F, 8'h80, 8'h00);
    run_pulse(3'b001, "negsat");

    // reset in the middle of a run
    load_mem(1'b0);
    sb[0].push_back({8'd64, 8'd10});
    base = ack_cnt[0];
    @(posedge clk);
    #1 req = 3'b001;
    @(posedge clk);
    #1 req = 3'b000;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrun_reset_busy_trigw", {busy[0], trig_w[0]}, 0);
    repeat (80) @(negedge clk);
    check("midrun_reset_no_ack", ack_cnt[0], base);
    check("midrun_reset_pending_writes", sb[0].size(), 0);
    push_run(0, 8'd10, 8'hF6, 8'd127, 8'd0);
    run_pulse(3'b001, "after_reset");

    // req held high: back-to-back runs
    for (int r = 0; r < 3; r++) push_run(0, 8'd10, 8'hF6, 8'd127, 8'd0);
    repeat (3) @(negedge clk);
    base = ack_cyc.size();
    @(posedge clk);
    #1 req = 3'b001;
    t0 = cyc;
    repeat (120) @(posedge clk);
    #1 req = 3'b000;
    for (int k = 0; k < 300 && ack_cyc.size() < base + 3; k++) @(negedge clk);
    check("held_ack_count", ack_cyc.size(), base + 3);
    if (ack_cyc.size() >= base + 2) begin
      check("held_first_ack_cycle", ack_cyc[base] - t0, 53);
      check("held_second_ack_cycle", ack_cyc[base + 1] - t0, 107);
    end else begin
      checks++;
      failures++;
      $display("FAIL held_ack_cycles actual=%0d acks required=2 or more", ack_cyc.size() - base);
    end

    repeat (5) @(negedge clk);
    for (int g = 0; g < 3; g++) check($sformatf("scoreboard_empty_dut%0d", g), sb[g].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
